// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus bundle: memory-controller IF port plus decoder-side FIFO head.
//   master (fetcher): drives if_enable/inst_addr and inst_valid/inst_out/inst_pc,
//                     samples if_ready/inst from memory and dec_ready from decoder.
//   slave  (environment): the mirror image.
interface inst_fetcher_if;
  logic        if_enable;
  logic [31:0] inst_addr;
  logic        if_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        dec_ready;

  modport master (
    output if_enable, inst_addr, inst_valid, inst_out, inst_pc,
    input  if_ready, inst, dec_ready
  );

  modport slave (
    input  if_enable, inst_addr, inst_valid, inst_out, inst_pc,
    output if_ready, inst, dec_ready
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: holds the fetch PC, issues one-word requests to the
// memory controller (one in flight), buffers {pc, inst} in a QDEPTH-entry FIFO
// drained by the decoder, and flushes/redirects on clear.
//   clk_in   : clock
//   rst_in   : synchronous active-high reset
//   rdy_in   : global ready, low freezes all state
//   clear    : flush and redirect to clear_pc (only when rdy_in=1)
//   clear_pc : redirect PC
//   bus      : memory IF port and decoder FIFO head (master modport)
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  inst_fetcher_if.master bus
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t       state_q;
  logic [31:0]  pc_q;
  logic         if_enable_q;
  logic [31:0]  inst_addr_q;
  logic [31:0]  mem_inst_q [QDEPTH];
  logic [31:0]  mem_pc_q   [QDEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic push_c;
  logic pop_c;

  // Word completes only while a request is outstanding; IDLE if_ready is ignored.
  assign push_c = (state_q == FETCH) && bus.if_ready;
  assign pop_c  = (count_q != '0) && bus.dec_ready;

  // Fetch FSM, PC and FIFO state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      if_enable_q <= 1'b0;
      inst_addr_q <= '0;
      mem_inst_q  <= '{default: '0};
      mem_pc_q    <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        // Coincident word and pop are both dropped; controller aborts on its own.
        state_q     <= IDLE;
        pc_q        <= clear_pc;
        if_enable_q <= 1'b0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
      end else begin
        if (state_q == IDLE) begin
          // Issue only with a free slot, so the eventual push cannot overflow.
          if (count_q < CW'(QDEPTH)) begin
            state_q     <= FETCH;
            if_enable_q <= 1'b1;
            inst_addr_q <= pc_q;
          end
        end else if (bus.if_ready) begin
          mem_inst_q[wr_ptr_q] <= bus.inst;
          mem_pc_q[wr_ptr_q]   <= pc_q;
          wr_ptr_q             <= wr_ptr_q + PW'(1);
          pc_q                 <= pc_q + 32'd4;
          if_enable_q          <= 1'b0;
          state_q              <= IDLE;
        end

        if (pop_c) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end

        case ({push_c, pop_c})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign bus.if_enable  = if_enable_q;
  assign bus.inst_addr  = inst_addr_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_out   = mem_inst_q[rd_ptr_q];
  assign bus.inst_pc    = mem_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: cycle-by-cycle vector table plus hand-written
// sequences for clear, freeze and PC wrap.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic [31:0] clear_pc;

  inst_fetcher_if bus_if ();

  inst_fetcher #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear    (clear),
    .clear_pc (clear_pc),
    .bus      (bus_if.master)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] inst;
    logic        dr;
    logic        en;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] out;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic ir, logic [31:0] inst, logic dr,
                              logic en, logic [31:0] addr, logic v,
                              logic [31:0] pc, logic [31:0] out);
    vec_t r;
    r.rst = rst; r.ir = ir; r.inst = inst; r.dr = dr;
    r.en = en; r.addr = addr; r.v = v; r.pc = pc; r.out = out;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, clock, then sample 1 time unit later.
  task automatic step(input logic rst, input logic rdy, input logic clr,
                      input logic [31:0] cpc, input logic ir,
                      input logic [31:0] inst, input logic dr);
    @(negedge clk_in);
    rst_in = rst; rdy_in = rdy; clear = clr; clear_pc = cpc;
    bus_if.if_ready = ir; bus_if.inst = inst; bus_if.dec_ready = dr;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc, input logic [31:0] out,
                         input logic chk_head);
    chk({tag, ".if_enable"}, 32'(bus_if.if_enable), 32'(en));
    chk({tag, ".inst_addr"}, bus_if.inst_addr, addr);
    chk({tag, ".inst_valid"}, 32'(bus_if.inst_valid), 32'(v));
    if (chk_head) begin
      chk({tag, ".inst_pc"}, bus_if.inst_pc, pc);
      chk({tag, ".inst_out"}, bus_if.inst_out, out);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; clear_pc = '0;
    bus_if.if_ready = 1'b0; bus_if.inst = '0; bus_if.dec_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Basic fetch, controller answers 3 cycles after each request, decoder always ready.
    tbl.push_back(mk(1, 0, 0,            1, 0, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hA000_0000, 1, 0, 32'h00, 1, 32'h00, 32'hA000_0000));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h04, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h04, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h04, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hA111_1111, 1, 0, 32'h04, 1, 32'h04, 32'hA111_1111));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h08, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h08, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h08, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hA222_2222, 1, 0, 32'h08, 1, 32'h08, 32'hA222_2222));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h0C, 0, 0, 0));
    // Reset mid-request, then fill to full with decoder stalled, then single pop.
    tbl.push_back(mk(1, 0, 0,            0, 0, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hB000_0000, 0, 0, 32'h00, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h04, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 1, 32'hB111_1111, 0, 0, 32'h04, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h08, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 1, 32'hB222_2222, 0, 0, 32'h08, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h0C, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 1, 32'hB333_3333, 0, 0, 32'h0C, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 0, 0,            0, 0, 32'h0C, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0C, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 0, 0,            0, 0, 32'h0C, 1, 32'h00, 32'hB000_0000));
    tbl.push_back(mk(0, 0, 0,            1, 0, 32'h0C, 1, 32'h04, 32'hB111_1111));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h10, 1, 32'h04, 32'hB111_1111));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h10, 1, 32'h04, 32'hB111_1111));
    // Two entries held, push and pop on the same edge, then drain to prove count=2.
    tbl.push_back(mk(1, 0, 0,            0, 0, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hC000_0000, 0, 0, 32'h00, 1, 32'h00, 32'hC000_0000));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h04, 1, 32'h00, 32'hC000_0000));
    tbl.push_back(mk(0, 1, 32'hC111_1111, 0, 0, 32'h04, 1, 32'h00, 32'hC000_0000));
    tbl.push_back(mk(0, 0, 0,            0, 1, 32'h08, 1, 32'h00, 32'hC000_0000));
    tbl.push_back(mk(0, 1, 32'hC222_2222, 1, 0, 32'h08, 1, 32'h04, 32'hC111_1111));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h0C, 1, 32'h08, 32'hC222_2222));
    tbl.push_back(mk(0, 0, 0,            1, 1, 32'h0C, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, 1'b1, 1'b0, 32'h0, tbl[i].ir, tbl[i].inst, tbl[i].dr);
      chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].addr, tbl[i].v,
              tbl[i].pc, tbl[i].out, tbl[i].v | tbl[i].rst);
    end

    // Clear coincident with if_ready and a pop, FIFO non-empty.
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'hD000_0000, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk_out("clr.pre", 1'b1, 32'h04, 1'b1, 32'h00, 32'hD000_0000, 1'b1);
    step(0, 1, 1, 32'h100, 1, 32'hD111_1111, 1);
    chk_out("clr.c1", 1'b0, 32'h04, 1'b0, 0, 0, 1'b0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk_out("clr.c2", 1'b1, 32'h100, 1'b0, 0, 0, 1'b0);
    step(0, 1, 0, 0, 1, 32'hD222_2222, 0);
    chk_out("clr.word", 1'b0, 32'h100, 1'b1, 32'h100, 32'hD222_2222, 1'b1);

    // Freeze during FETCH with if_ready/dec_ready/clear toggling.
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'hE000_0000, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, (k == 2), 32'h200, (k % 2 == 0), 32'hEEEE_0000 + 32'(k), (k != 2));
      chk_out($sformatf("frz%0d", k), 1'b1, 32'h04, 1'b1, 32'h00, 32'hE000_0000, 1'b1);
    end
    step(0, 1, 0, 0, 1, 32'hE111_1111, 0);
    chk_out("frz.resume", 1'b0, 32'h04, 1'b1, 32'h00, 32'hE000_0000, 1'b1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk_out("frz.pop", 1'b1, 32'h08, 1'b1, 32'h04, 32'hE111_1111, 1'b1);

    // Redirect to the top word, then wrap to zero.
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 1);
    chk_out("wrap.clr", 1'b0, 32'h0, 1'b0, 0, 0, 1'b0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk_out("wrap.req0", 1'b1, 32'hFFFF_FFFC, 1'b0, 0, 0, 1'b0);
    step(0, 1, 0, 0, 1, 32'hF000_0000, 0);
    chk_out("wrap.ret0", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hF000_0000, 1'b1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk_out("wrap.req1", 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);
    step(0, 1, 0, 0, 1, 32'hF111_1111, 0);
    chk_out("wrap.ret1", 1'b0, 32'h0, 1'b1, 32'h0, 32'hF111_1111, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch stage between the PC logic and the memory controller. Holds the fetch PC and issues one-word instruction fetch requests to the memory controller's IF port. Buffers returned instructions with their PCs in a small FIFO that the decoder drains. On `clear` it flushes the FIFO and any in-flight request, then restarts fetching at a redirect PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, fetch PC after reset.
- `QDEPTH`, default 4, instruction FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk_in` in 1: system clock; single clock domain.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global ready; when low, all state freezes.
- `clear` in 1: pipeline flush/redirect, sampled only when `rdy_in`=1.
- `clear_pc` in 32: new fetch PC, valid with `clear`.
- `if_enable` out 1: fetch request to memory controller (registered).
- `inst_addr` out 32: fetch address, stable while `if_enable`=1 (registered).
- `if_ready` in 1: memory controller word complete.
- `inst` in 32: fetched word, valid when `if_ready`=1.
- `inst_valid` out 1: FIFO non-empty.
- `inst_out` out 32: FIFO head instruction.
- `inst_pc` out 32: FIFO head PC.
- `dec_ready` in 1: decoder consumes head when `inst_valid`=1.

## Operation
- Priority: `rst_in` > (`rdy_in` && `clear`) > normal (`rdy_in`=1) > freeze (`rdy_in`=0).
- Reset values:
  - `pc`=RESET_PC; state IDLE.
  - `if_enable`=0; `inst_addr`=0.
  - FIFO empty: `inst_valid`=0; `inst_out`=0; `inst_pc`=0.
- FSM states:
  - IDLE → FETCH when FIFO count < QDEPTH.
    - Sets `if_enable`<=1, `inst_addr`<=pc.
  - FETCH: holds `if_enable`=1 and `inst_addr`.
    - Transition occurs on the edge where `if_ready`=1 is sampled.
    - Pushes {pc, `inst`} to the FIFO.
    - `pc`<=pc+4, wrapping modulo 2^32.
    - `if_enable`<=0; state → IDLE.
- At most one request in flight.
  - A request is issued only when the FIFO has a free slot.
  - Therefore a push never overflows.
- `if_ready` sampled in IDLE is ignored.
- Pop: when `inst_valid` && `dec_ready`, the head is removed at the edge.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push into an empty FIFO is visible on `inst_valid` the next cycle; there is no bypass.
- FIFO pointers wrap modulo QDEPTH; count range is 0..QDEPTH.
- Clear (`rdy_in`=1, `clear`=1):
  - FIFO is emptied; `pc`<=`clear_pc`.
  - State → IDLE; `if_enable`<=0.
  - A coincident `if_ready`/`inst` is discarded, and a coincident pop is void.
  - The memory controller aborts its own transfer on the same `clear`.
- `rdy_in`=0: no register changes, and `if_ready`/`dec_ready` are ignored.
- `inst_out`/`inst_pc` are don't-care when `inst_valid`=0; they reset to 0.

## Timing
- Edge E: IDLE with space. At E+1, `if_enable`=1 and `inst_addr`=pc.
- `if_ready` sampled high at edge F. At F+1:
  - entry is in the FIFO;
  - `if_enable`=0;
  - `pc` has advanced by 4.
- At F+1 the FSM is IDLE. Next request is asserted at F+2 if space remains.
  - Minimum one idle cycle between requests.
- Fetch-to-decoder latency: `inst_valid` rises the cycle after `if_ready` (into an empty FIFO).
- FIFO full:
  - No new `if_enable` until a pop.
  - After the popping edge, count < QDEPTH; `if_enable` rises one edge later.
- After clear at edge C:
  - C+1: IDLE, empty, `pc`=`clear_pc`.
  - C+2: `if_enable`=1, `inst_addr`=`clear_pc`.
- Mid-request reset or clear: `if_enable` is low the next cycle; no partial entry is pushed.

## Test plan
- Reset, RESET_PC=0, `dec_ready`=1, controller returns `if_ready` 3 cycles after each request.
  - Required: `inst_addr` sequence 0, 4, 8.
  - Required: `inst_pc`/`inst_out` match the returned words, in order.
- `dec_ready`=0, words returned promptly.
  - Required: exactly 4 pushes (QDEPTH=4), then `if_enable` stays 0.
  - Then a single `dec_ready` pulse: one pop, `if_enable` rises 1 cycle later, `inst_addr`=16.
- FIFO holds 2 entries; pop and `if_ready` fall on the same edge.
  - Required: count stays 2; head advances; new tail PC = previous tail PC + 4.
- `clear` with `clear_pc`=0x100 on the same edge as `if_ready`.
  - Required: word discarded, `inst_valid`=0 next cycle.
  - Required: `inst_addr`=0x100 two cycles after clear.
- `rdy_in`=0 for 5 cycles during FETCH, with `if_ready` and `dec_ready` toggling.
  - Required: all outputs and state unchanged.
  - Required: resumes exactly when `rdy_in`=1.
- Redirect to `clear_pc`=0xFFFFFFFC, then two fetches.
  - Required: `inst_addr` 0xFFFFFFFC then 0x00000000.
